// File: rtl/alu_pkg.sv
// Shared ALU definitions: RED operand ranges, lane limits and the split FSM states.
package alu_pkg;

    typedef logic signed [15:0] sum_t;
    typedef logic signed [7:0]  lane_t;

    localparam sum_t RED_MIN  = -16'sd512;
    localparam sum_t RED_MAX  =  16'sd508;
    localparam sum_t LANE_MIN = -16'sd128;
    localparam sum_t LANE_MAX =  16'sd127;

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DONE
    } state_e;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; chained to build wider adders.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/sat_clamp8.sv
// Combinational signed clamp of a 16-bit value into one 8-bit lane.
module sat_clamp8
    import alu_pkg::*;
(
    input  sum_t  val,
    output lane_t lane,
    output sum_t  lane_ext
);

    // lane_ext is the clamped amount at full width, ready to subtract from val
    always_comb begin
        if (val > LANE_MAX) begin
            lane_ext = LANE_MAX;
        end else if (val < LANE_MIN) begin
            lane_ext = LANE_MIN;
        end else begin
            lane_ext = val;
        end
    end

    assign lane = lane_ext[7:0];

endmodule

// File: rtl/red_split_seq.sv
// Splits a signed target into four signed byte lanes whose sum equals it, one lane per cycle.
module red_split_seq
    import alu_pkg::*;
#(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        A,
    output logic [15:0]        B,
    output logic               err
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int SUM_W = 16;
    localparam int NIB   = SUM_W / 4;

    state_e state_q;
    state_e state_d;

    logic signed [SUM_W-1:0]  remaining_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [LANE_W-1:0] lane_q [NUM_LANES];
    logic                     err_q;

    logic  accept;
    logic  in_range;
    logic  last_lane;
    lane_t lane_val;
    sum_t  lane_ext;
    sum_t  remaining_d;

    logic [SUM_W-1:0] lane_inv;
    logic [SUM_W-1:0] diff;
    logic [NIB:0]     carry;
    logic             sub_ovf;

    assign accept    = in_valid & in_ready;
    assign in_range  = (target >= RED_MIN) && (target <= RED_MAX);
    assign last_lane = (idx_q == IDX_W'(NUM_LANES - 1));

    sat_clamp8 u_clamp (
        .val      (remaining_q),
        .lane     (lane_val),
        .lane_ext (lane_ext)
    );

    // remaining - lane_ext as remaining + ~lane_ext + 1 through the CLA chain
    assign lane_inv = ~lane_ext;
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NIB; g++) begin : g_cla
        cla4 u_cla (
            .a  (remaining_q[4*g +: 4]),
            .b  (lane_inv[4*g +: 4]),
            .ci (carry[g]),
            .s  (diff[4*g +: 4]),
            .co (carry[g+1])
        );
    end

    assign remaining_d = $signed(diff);
    assign sub_ovf     = remaining_q[SUM_W-1] ^ lane_inv[SUM_W-1] ^ carry[NIB] ^ diff[SUM_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = in_range ? SPLIT : DONE;
            SPLIT:   if (last_lane) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Lanes clear on every accept so unwritten lanes always read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
            idx_q       <= '0;
            remaining_q <= in_range ? target : '0;
            err_q       <= ~in_range;
        end else if (state_q == SPLIT) begin
            lane_q[idx_q] <= lane_val;
            remaining_q   <= remaining_d;
            idx_q         <= idx_q + 1'b1;
        end
    end

    assign A   = {lane_q[3], lane_q[2]};
    assign B   = {lane_q[1], lane_q[0]};
    assign err = err_q;

    // Greedy clamping always drains an in-range target by the last lane
    a_no_residue: assert property (@(posedge clk) disable iff (rst)
        state_q == DONE |-> remaining_q == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        state_q == SPLIT |-> !sub_ovf);

endmodule

// File: doc/red_split_seq.md
Name: red_split_seq

Overview:
- Inverse of the RED reduction datapath: takes a 16-bit two's-complement target sum and produces operands A, B whose four signed bytes sum exactly to it.
- RED(A,B) = A[15:8]+A[7:0]+B[15:8]+B[7:0], each byte signed.
- Sequential, one byte lane resolved per cycle, valid/ready handshake on both sides.
- Used by the verification harness and the self-test loader to generate RED operands for a known result; sits beside the ALU, off the critical path.

Parameters:
- LANE_W, 8, width of one signed lane. Fixed at 8 for this processor; other values are not supported.
- NUM_LANES, 4, lanes per operand pair (two per 16-bit operand). Fixed at 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  target value presented.
- in_ready  output  1  block can accept a target.
- target  input  16  signed target sum.
- out_valid  output  1  A/B/err valid.
- out_ready  input  1  consumer accepts the result.
- A  output  16  {lane3, lane2}.
- B  output  16  {lane1, lane0}.
- err  output  1  target outside the representable range.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, A=0, B=0, err=0, state=IDLE, remaining=0, lane index=0.
- States:
  - IDLE: in_ready=1.
    - in_valid&in_ready at an edge captures target.
    - Valid range is -512..+508 inclusive. In range -> remaining=target, idx=0, go to SPLIT.
    - Out of range -> A=B=0, err=1, go to DONE.
  - SPLIT: in_ready=0. On each edge:
    - lane[idx] = clamp(remaining, -128, +127).
    - remaining -= lane[idx], computed at 16 bits and sign-correct.
    - idx++.
    - After the edge writing lane3, go to DONE with err=0.
  - DONE: out_valid=1; A, B and err are held stable.
    - out_valid&out_ready at an edge -> IDLE. A, B and err keep their last values; only out_valid drops.
- Latency:
  - In-range target: out_valid rises 5 edges after the accept edge (1 capture + 4 lane edges).
  - Error case: out_valid rises 1 edge after the accept edge.
- Greedy clamp guarantees remaining=0 after lane3 for any in-range target. Nonzero residue is an assertion failure, not a runtime output.
- No overlap: a new target is accepted only in IDLE. A DONE->IDLE edge never also accepts; acceptance happens at the next edge at the earliest.
- out_ready may be held high permanently; this gives a 6-cycle turnaround per target.
- in_valid deasserting while in SPLIT or DONE is ignored. target is not sampled outside IDLE.
- Reset mid-operation (SPLIT or DONE) aborts immediately: all registers return to their reset values and the partial result is discarded.
- Unused lanes are never left undefined. Lanes not yet written hold 0, because lane registers clear on accept.

Decomposition:
- Shared package (alu_pkg) holds:
  - RED_MIN=-512, RED_MAX=508.
  - LANE_MIN=-128, LANE_MAX=127.
  - The state enum {IDLE, SPLIT, DONE}.
- One natural sub-module: sat_clamp8, a combinational 16-bit-to-8-bit signed clamp that also returns the clamped amount. It is reused by the PADDSB saturation logic.
- The FSM, lane registers and the 16-bit subtract stay in red_split_seq. The subtract reuses the existing 4-bit CLA adders, chained ×4.

Test Plan:
- Reset, then target=0x012C (300), out_ready=1 -> after 5 edges out_valid=1, A=0x002E, B=0x7F7F, err=0. RED(A,B) must equal 300.
- target=0xFE00 (-512) -> A=0x8080, B=0x8080, err=0. target=0x01FC (508) -> A=0x7F7F, B=0x7F7F.
- target=0x01FD (509) and target=0xFDFF (-513) -> out_valid 1 edge after accept, err=1, A=B=0.
- out_ready held 0 for 10 cycles in DONE -> A, B, err and out_valid stable. Then pulse out_ready -> IDLE, in_ready=1 next cycle.
- rst asserted on the 2nd SPLIT edge -> next cycle all outputs at reset values, in_ready=1, and no out_valid follows.
- Random sweep of -512..508 back-to-back with random out_ready stalls -> every result satisfies RED(A,B)==target and err=0. Scoreboard uses the RED reference model.
